clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
Time-setting controller for the 24 h HH:MM:SS clock. It debounces the two user keys and runs the mode FSM RUN -> SET_HOUR -> SET_MIN -> RUN. It issues single-cycle increment pulses to the hour and minute counter chains and gates the seconds chain while the user is setting the time. It also produces the digit-blank mask that makes the field being edited blink on the 7-segment displays.

Parameters:
DEB_CYC, 1_000_000, debounce stability window in i_clk cycles (20 ms at 50 MHz); must be >= 2
BLINK_CYC, 25_000_000, i_clk cycles per blink half-period
TIMEOUT_S, 10, i_tick_1hz pulses without a key press before a SET state auto-returns to RUN

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, synchronous, active-low
i_key_mode_n  in  1  raw mode key, active-low, asynchronous, bouncing
i_key_inc_n  in  1  raw increment key, active-low, asynchronous, bouncing
i_tick_1hz  in  1  one-cycle 1 Hz reference pulse
o_run_en  out  1  1 = seconds chain may count; top ANDs it with the 1 Hz tick and the minute-to-hour carry
o_sec_clr  out  1  one-cycle pulse; synchronous clear of both seconds digits
o_min_inc  out  1  one-cycle pulse into the minute-units counter enable
o_hour_inc  out  1  one-cycle pulse into the hour-units counter enable
o_blank  out  2  [1] blank hour digits, [0] blank minute digits
o_mode  out  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN (3 is never driven)

Behaviour:
- Reset (i_rst_n = 0 at a rising edge):
  - state RUN; o_run_en = 1; o_sec_clr, o_min_inc, o_hour_inc = 0; o_blank = 00; o_mode = 0.
  - Synchronizer flops and debounced levels reset to 1 (released). All counters reset to 0.
  - Reset asserted mid-operation aborts any SET state with no pulses emitted.
- Key path (identical for each key):
  - 2-flop synchronizer.
  - Debounce counter: increments while the synced level differs from the debounced level. It clears whenever they are equal. On reaching DEB_CYC-1 with a mismatch, the debounced level takes the synced level and the counter clears.
  - Press event = registered 1->0 transition of the debounced level. Exactly one cycle wide.
  - Latency from a clean raw edge to the press pulse is fixed at DEB_CYC+3 cycles.
  - Releases generate no event. A glitch shorter than DEB_CYC cycles generates nothing.
- FSM, evaluated on press events:
  - RUN: mode press -> SET_HOUR. Inc press is ignored.
  - SET_HOUR: inc press -> o_hour_inc pulse. Mode press -> SET_MIN.
  - SET_MIN: inc press -> o_min_inc pulse. Mode press -> RUN.
  - Every SET_MIN -> RUN transition pulses o_sec_clr in the same cycle o_mode returns to 0.
  - Mode and inc press in the same cycle: the mode press wins and the inc press is dropped.
  - Increment pulses are registered: they appear one cycle after the press pulse. Wrap (23 -> 00, 59 -> 00) is handled by the counters, not here.
- o_run_en = (state == RUN), registered with the state. In SET states the seconds chain and the minute-to-hour carry are frozen.
- Timeout:
  - The timeout counter counts i_tick_1hz pulses only in SET states. It clears on any press event and on entry to any state.
  - When the counter would reach TIMEOUT_S: state -> RUN with an o_sec_clr pulse, and no increment is issued.
  - A press and a tick in the same cycle: the press wins and the counter clears.
- Blink:
  - The blink counter free-runs 0..BLINK_CYC-1; the phase toggles on wrap.
  - Counter and phase (visible = 0) reset on every state change, so a new field always starts visible.
  - o_blank[1] = (state == SET_HOUR) & phase. o_blank[0] = (state == SET_MIN) & phase.
  - o_blank = 00 in RUN.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
Overrides for all scenarios: DEB_CYC = 4, BLINK_CYC = 8, TIMEOUT_S = 3.
1. Reset:
   - Stimulus: hold i_rst_n = 0 for 3 cycles with both keys low, then release with keys high.
   - Required: o_mode = 0, o_run_en = 1, o_blank = 00, no pulses for 20 cycles.
2. Debounce:
   - Stimulus: mode key low 3 cycles then high, then low 10 cycles.
   - Required: no event for the glitch. Exactly one press, with o_mode = 1 at cycle 7 (DEB_CYC+3) after the stable edge.
3. Mode cycle:
   - Stimulus: three clean mode presses.
   - Required: o_mode sequence 1, 2, 0. o_run_en 0 in SET states. Exactly one o_sec_clr pulse, coincident with o_mode = 0.
4. Increments:
   - Stimulus: inc press in RUN.
   - Required: no pulse.
   - Stimulus: mode press, then 2 inc presses.
   - Required: 2 o_hour_inc pulses, 0 o_min_inc.
   - Stimulus: mode press, then 1 inc press.
   - Required: 1 o_min_inc pulse.
   - Stimulus: mode and inc pressed in the same cycle.
   - Required: mode advances and no increment is issued.
5. Timeout:
   - Stimulus: in SET_MIN, 3 ticks with no press.
   - Required: o_mode = 0 plus an o_sec_clr pulse on the 3rd tick.
   - Stimulus: 2 ticks, an inc press, then 2 ticks.
   - Required: remains in SET_MIN.
6. Blink and reset:
   - Stimulus: enter SET_HOUR.
   - Required: o_blank = 00 for 8 cycles, then 10 for 8 cycles, repeating.
   - Stimulus: assert i_rst_n = 0 mid-SET_HOUR.
   - Required: o_blank = 00 and o_mode = 0 next cycle, with no o_sec_clr.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the 24 h HH:MM:SS clock.
// Debounces the mode and increment keys and runs the RUN -> SET_HOUR -> SET_MIN
// mode FSM. It issues increment pulses to the hour and minute chains, freezes
// the seconds chain while a field is being set, and drives the blink mask for
// the digits under edit.

// Key conditioner: 2-flop synchronizer, stability-window debounce and a press
// strobe on the debounced 1->0 transition.
module clock_set_key #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int DEB_W = $clog2(DEB_CYC);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             deb_r;
  logic             deb_d_r;
  logic [DEB_W-1:0] cnt_r;

  // Synchronize the raw key, then accept a new level only after it has differed from the debounced level for DEB_CYC samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      deb_r   <= 1'b1;
      deb_d_r <= 1'b1;
      cnt_r   <= {DEB_W{1'b0}};
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      if (sync2_r == deb_r) begin
        cnt_r <= {DEB_W{1'b0}};
      end else if (cnt_r == DEB_LAST) begin
        deb_r <= sync2_r;
        cnt_r <= {DEB_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + DEB_W'(1);
      end
    end
  end

  // Press fires for the single cycle after the debounced level falls; releases are ignored
  assign press = deb_d_r & ~deb_r;
endmodule

module clock_set_ctrl #(
  parameter int DEB_CYC   = 1_000_000,
  parameter int BLINK_CYC = 25_000_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_mode_n,
  input  logic       i_key_inc_n,
  input  logic       i_tick_1hz,
  output logic       o_run_en,
  output logic       o_sec_clr,
  output logic       o_min_inc,
  output logic       o_hour_inc,
  output logic [1:0] o_blank,
  output logic [1:0] o_mode
);
  localparam int BLINK_W = $clog2(BLINK_CYC);
  localparam int TMO_W   = $clog2(TIMEOUT_S + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_S - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [TMO_W-1:0]     tmo_cnt_r;
  logic [TMO_W-1:0]     tmo_cnt_nxt_s;
  logic [BLINK_W-1:0]   blink_cnt_r;
  logic [BLINK_W-1:0]   blink_cnt_nxt_s;
  logic                 phase_r;
  logic                 phase_nxt_s;
  logic                 mode_press_s;
  logic                 inc_press_s;
  logic                 tmo_hit_s;
  logic                 state_chg_s;
  logic                 hour_inc_nxt_s;
  logic                 min_inc_nxt_s;
  logic                 sec_clr_nxt_s;
  logic [1:0]           blank_nxt_s;

  clock_set_key #(.DEB_CYC(DEB_CYC)) u_key_mode (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .key_n (i_key_mode_n),
    .press (mode_press_s)
  );

  clock_set_key #(.DEB_CYC(DEB_CYC)) u_key_inc (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .key_n (i_key_inc_n),
    .press (inc_press_s)
  );

  // Next state, output pulses, timeout and blink counters; mode press outranks inc press, any press outranks timeout
  always_comb begin
    state_nxt_s    = state_r;
    hour_inc_nxt_s = 1'b0;
    min_inc_nxt_s  = 1'b0;
    sec_clr_nxt_s  = 1'b0;
    tmo_hit_s      = i_tick_1hz & (tmo_cnt_r == TMO_LAST) & ~mode_press_s & ~inc_press_s;

    case (state_r)
      ST_RUN: begin
        if (mode_press_s) begin
          state_nxt_s = ST_SET_HOUR;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_SET_HOUR: begin
        if (mode_press_s) begin
          state_nxt_s = ST_SET_MIN;
        end else if (inc_press_s) begin
          hour_inc_nxt_s = 1'b1;
        end else if (tmo_hit_s) begin
          state_nxt_s   = ST_RUN;
          sec_clr_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_SET_HOUR;
        end
      end
      ST_SET_MIN: begin
        if (mode_press_s) begin
          state_nxt_s   = ST_RUN;
          sec_clr_nxt_s = 1'b1;
        end else if (inc_press_s) begin
          min_inc_nxt_s = 1'b1;
        end else if (tmo_hit_s) begin
          state_nxt_s   = ST_RUN;
          sec_clr_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_SET_MIN;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase

    state_chg_s = (state_nxt_s != state_r);

    // Timeout only accumulates ticks while idling inside a SET state
    if (state_chg_s || (state_r == ST_RUN) || mode_press_s || inc_press_s) begin
      tmo_cnt_nxt_s = {TMO_W{1'b0}};
    end else if (i_tick_1hz) begin
      tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_nxt_s = tmo_cnt_r;
    end

    // A freshly selected field always starts in its visible phase
    if (state_chg_s) begin
      blink_cnt_nxt_s = {BLINK_W{1'b0}};
      phase_nxt_s     = 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_nxt_s = {BLINK_W{1'b0}};
      phase_nxt_s     = ~phase_r;
    end else begin
      blink_cnt_nxt_s = blink_cnt_r + BLINK_W'(1);
      phase_nxt_s     = phase_r;
    end

    blank_nxt_s = {(state_nxt_s == ST_SET_HOUR) & phase_nxt_s,
                   (state_nxt_s == ST_SET_MIN)  & phase_nxt_s};
  end

  // State, counters and all outputs registered together so no input reaches an output combinationally
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= ST_RUN;
      tmo_cnt_r   <= {TMO_W{1'b0}};
      blink_cnt_r <= {BLINK_W{1'b0}};
      phase_r     <= 1'b0;
      o_run_en    <= 1'b1;
      o_sec_clr   <= 1'b0;
      o_min_inc   <= 1'b0;
      o_hour_inc  <= 1'b0;
      o_blank     <= 2'b00;
      o_mode      <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      tmo_cnt_r   <= tmo_cnt_nxt_s;
      blink_cnt_r <= blink_cnt_nxt_s;
      phase_r     <= phase_nxt_s;
      o_run_en    <= (state_nxt_s == ST_RUN);
      o_sec_clr   <= sec_clr_nxt_s;
      o_min_inc   <= min_inc_nxt_s;
      o_hour_inc  <= hour_inc_nxt_s;
      o_blank     <= blank_nxt_s;
      o_mode      <= state_nxt_s;
    end
  end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl with short debounce, blink
// and timeout parameters so every behaviour fits in a few hundred cycles.
module tb_clock_set_ctrl;
  localparam int DEB_CYC   = 4;
  localparam int BLINK_CYC = 8;
  localparam int TIMEOUT_S = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_mode_n;
  logic       key_inc_n;
  logic       tick;
  logic       run_en;
  logic       sec_clr;
  logic       min_inc;
  logic       hour_inc;
  logic [1:0] blank;
  logic [1:0] mode;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_hour;
  int cnt_min;
  int cnt_clr;
  int cnt_clr_bad;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .DEB_CYC   (DEB_CYC),
    .BLINK_CYC (BLINK_CYC),
    .TIMEOUT_S (TIMEOUT_S)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_key_mode_n (key_mode_n),
    .i_key_inc_n  (key_inc_n),
    .i_tick_1hz   (tick),
    .o_run_en     (run_en),
    .o_sec_clr    (sec_clr),
    .o_min_inc    (min_inc),
    .o_hour_inc   (hour_inc),
    .o_blank      (blank),
    .o_mode       (mode)
  );

  // Advance n cycles, sampling 1 time unit after each rising edge and tallying pulses
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (hour_inc === 1'b1) cnt_hour++;
      if (min_inc === 1'b1) cnt_min++;
      if (sec_clr === 1'b1) cnt_clr++;
      if (sec_clr === 1'b1 && mode !== 2'd0) cnt_clr_bad++;
    end
  endtask

  task automatic clear_counts();
    cnt_hour = 0;
    cnt_min = 0;
    cnt_clr = 0;
    cnt_clr_bad = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_mode_n = 1'b1;
    key_inc_n = 1'b1;
    tick = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    clear_counts();
  endtask

  // Clean press: low long enough to register (effect visible on the last low cycle), then a full release
  task automatic press(input bit m, input bit i);
    if (m) key_mode_n = 1'b0;
    if (i) key_inc_n = 1'b0;
    cyc(DEB_CYC + 3);
    key_mode_n = 1'b1;
    key_inc_n = 1'b1;
    cyc(DEB_CYC + 4);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_mode_n = 1'b0;
    key_inc_n = 1'b0;
    tick = 1'b0;
    cyc(3);
    n_cmp++;
    if ({mode, run_en, blank} !== 5'b00_1_00) begin
      n_bad++;
      $display("FAIL reset_hold: got mode/run/blank=%b required %b", {mode, run_en, blank}, 5'b00_1_00);
    end
    rst_n = 1'b1;
    key_mode_n = 1'b1;
    key_inc_n = 1'b1;
    clear_counts();
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      n_cmp++;
      if ({mode, run_en, blank, sec_clr, min_inc, hour_inc} !== 8'b00_1_00_000) begin
        n_bad++;
        $display("FAIL reset_idle cycle %0d: got %b required %b", c,
                 {mode, run_en, blank, sec_clr, min_inc, hour_inc}, 8'b00_1_00_000);
      end
    end
  endtask

  task automatic test_debounce();
    logic [1:0] exp_mode;
    do_reset();
    key_mode_n = 1'b0;
    cyc(3);
    key_mode_n = 1'b1;
    cyc(12);
    n_cmp++;
    if (mode !== 2'd0) begin
      n_bad++;
      $display("FAIL deb_glitch: got mode=%0d required 0", mode);
    end
    key_mode_n = 1'b0;
    for (int s = 1; s <= 10; s++) begin
      cyc(1);
      exp_mode = (s >= DEB_CYC + 3) ? 2'd1 : 2'd0;
      n_cmp++;
      if (mode !== exp_mode) begin
        n_bad++;
        $display("FAIL deb_latency step %0d: got mode=%0d required %0d", s, mode, exp_mode);
      end
    end
    key_mode_n = 1'b1;
    cyc(10);
    n_cmp++;
    if ({mode, run_en} !== 3'b01_0) begin
      n_bad++;
      $display("FAIL deb_single_press: got mode/run=%b required %b", {mode, run_en}, 3'b01_0);
    end
  endtask

  task automatic test_mode_cycle();
    logic [2:0] exp_seq [3];
    exp_seq[0] = 3'b01_0;
    exp_seq[1] = 3'b10_0;
    exp_seq[2] = 3'b00_1;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      press(1'b1, 1'b0);
      n_cmp++;
      if ({mode, run_en} !== exp_seq[p]) begin
        n_bad++;
        $display("FAIL mode_cycle press %0d: got mode/run=%b required %b", p, {mode, run_en}, exp_seq[p]);
      end
    end
    n_cmp++;
    if (cnt_clr !== 1 || cnt_clr_bad !== 0) begin
      n_bad++;
      $display("FAIL mode_cycle_secclr: got %0d pulses (%0d misaligned) required 1 (0)", cnt_clr, cnt_clr_bad);
    end
  endtask

  task automatic test_increments();
    do_reset();
    press(1'b0, 1'b1);
    n_cmp++;
    if (mode !== 2'd0 || cnt_hour !== 0 || cnt_min !== 0) begin
      n_bad++;
      $display("FAIL inc_in_run: got mode=%0d hour=%0d min=%0d required 0 0 0", mode, cnt_hour, cnt_min);
    end
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    n_cmp++;
    if (mode !== 2'd1 || cnt_hour !== 2 || cnt_min !== 0) begin
      n_bad++;
      $display("FAIL inc_hour: got mode=%0d hour=%0d min=%0d required 1 2 0", mode, cnt_hour, cnt_min);
    end
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    n_cmp++;
    if (mode !== 2'd2 || cnt_hour !== 2 || cnt_min !== 1) begin
      n_bad++;
      $display("FAIL inc_min: got mode=%0d hour=%0d min=%0d required 2 2 1", mode, cnt_hour, cnt_min);
    end
    press(1'b1, 1'b1);
    n_cmp++;
    if (mode !== 2'd0 || cnt_hour !== 2 || cnt_min !== 1 || cnt_clr !== 1) begin
      n_bad++;
      $display("FAIL inc_simultaneous: got mode=%0d hour=%0d min=%0d clr=%0d required 0 2 1 1",
               mode, cnt_hour, cnt_min, cnt_clr);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    clear_counts();
    pulse_tick();
    cyc(2);
    pulse_tick();
    cyc(2);
    n_cmp++;
    if (mode !== 2'd2) begin
      n_bad++;
      $display("FAIL tmo_two_ticks: got mode=%0d required 2", mode);
    end
    pulse_tick();
    n_cmp++;
    if ({mode, sec_clr, run_en} !== 4'b00_1_1) begin
      n_bad++;
      $display("FAIL tmo_expire: got mode/clr/run=%b required %b", {mode, sec_clr, run_en}, 4'b00_1_1);
    end
    n_cmp++;
    if (cnt_clr !== 1 || cnt_min !== 0 || cnt_hour !== 0) begin
      n_bad++;
      $display("FAIL tmo_pulses: got clr=%0d min=%0d hour=%0d required 1 0 0", cnt_clr, cnt_min, cnt_hour);
    end
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    clear_counts();
    pulse_tick();
    pulse_tick();
    press(1'b0, 1'b1);
    pulse_tick();
    pulse_tick();
    n_cmp++;
    if (mode !== 2'd2 || cnt_min !== 1 || cnt_clr !== 0) begin
      n_bad++;
      $display("FAIL tmo_restart: got mode=%0d min=%0d clr=%0d required 2 1 0", mode, cnt_min, cnt_clr);
    end
    pulse_tick();
    n_cmp++;
    if (mode !== 2'd0 || cnt_clr !== 1) begin
      n_bad++;
      $display("FAIL tmo_restart_expire: got mode=%0d clr=%0d required 0 1", mode, cnt_clr);
    end
  endtask

  task automatic test_blink_reset();
    logic [3:0] exp_v;
    do_reset();
    key_mode_n = 1'b0;
    cyc(DEB_CYC + 2);
    n_cmp++;
    if (mode !== 2'd0) begin
      n_bad++;
      $display("FAIL blink_pre_entry: got mode=%0d required 0", mode);
    end
    cyc(1);
    for (int i = 0; i < 28; i++) begin
      if (i > 0) begin
        key_mode_n = 1'b1;
        cyc(1);
      end
      exp_v = {2'd1, (((i / BLINK_CYC) % 2) == 1) ? 2'b10 : 2'b00};
      n_cmp++;
      if ({mode, blank} !== exp_v) begin
        n_bad++;
        $display("FAIL blink cycle %0d: got mode/blank=%b required %b", i, {mode, blank}, exp_v);
      end
    end
    clear_counts();
    rst_n = 1'b0;
    cyc(1);
    n_cmp++;
    if ({mode, blank, run_en, sec_clr} !== 6'b00_00_1_0) begin
      n_bad++;
      $display("FAIL reset_mid_set: got mode/blank/run/clr=%b required %b",
               {mode, blank, run_en, sec_clr}, 6'b00_00_1_0);
    end
    rst_n = 1'b1;
    cyc(3);
    n_cmp++;
    if (mode !== 2'd0 || cnt_clr !== 0 || cnt_hour !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_set_after: got mode=%0d clr=%0d hour=%0d required 0 0 0", mode, cnt_clr, cnt_hour);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key_mode_n = 1'b1;
    key_inc_n = 1'b1;
    tick = 1'b0;
    clear_counts();
    test_reset();
    test_debounce();
    test_mode_cycle();
    test_increments();
    test_timeout();
    test_blink_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
